// File: rtl/systolic_os_array_pkg.sv
// Shared types for the output-stationary systolic array.
// FSM state encoding and accumulator width derivation.
package systolic_os_array_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FEED,
    S_FLUSH,
    S_DRAIN
  } state_e;

  function automatic int acc_width(int dw, int kmax);
    return 2 * dw + $clog2(kmax);
  endfunction

endpackage

// File: rtl/systolic_os_pe.sv
// Single processing element: signed MAC with operand forwarding.
// clr zeroes the accumulator and forwarding registers synchronously.
module systolic_os_pe #(
  parameter int DW   = 16,
  parameter int ACCW = 40
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   en,
  input  logic signed [DW-1:0]   a_in,
  input  logic signed [DW-1:0]   b_in,
  output logic signed [DW-1:0]   a_out,
  output logic signed [DW-1:0]   b_out,
  output logic signed [ACCW-1:0] acc
);

  logic signed [2*DW-1:0] prod;

  assign prod = a_in * b_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (en)
        acc <= acc + ACCW'(prod);
    end
  end

endmodule

// File: rtl/systolic_os_array.sv
// Output-stationary ROWS x COLS systolic MAC array with row drain.
// Define SYSTOLIC_OUT_SAT_EN to saturate output lanes instead of wrapping.
module systolic_os_array
  import systolic_os_array_pkg::*;
#(
  parameter int DW   = 16,
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int KMAX = 256,
  parameter int ACCW = acc_width(DW, KMAX)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(KMAX+1)-1:0]  k_len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ROWS*DW-1:0]         ifmap_in,
  input  logic [COLS*DW-1:0]         weight_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(ROWS)-1:0]    out_row,
  output logic [COLS*DW-1:0]         out_data,
  output logic                       busy,
  output logic                       done
);

  localparam int KW = $clog2(KMAX + 1);
  localparam int RW = $clog2(ROWS);
  localparam int FW = $clog2(ROWS + COLS);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(ROWS + COLS - 2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(ROWS - 1);

  state_e        state;
  logic [KW-1:0] klen_q;
  logic [KW-1:0] cnt;
  logic [FW-1:0] fcnt;
  logic          fire;
  logic          clr;
  logic          en;

  logic signed [DW-1:0]   a_inj  [ROWS];
  logic signed [DW-1:0]   b_inj  [COLS];
  logic signed [DW-1:0]   a_bus  [ROWS][COLS+1];
  logic signed [DW-1:0]   b_bus  [ROWS+1][COLS];
  logic signed [ACCW-1:0] acc_arr [ROWS][COLS];

  assign fire = in_valid & in_ready;
  assign clr  = (state == S_IDLE) & start;
  assign en   = (state == S_FEED) | (state == S_FLUSH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      klen_q    <= '0;
      cnt       <= '0;
      fcnt      <= '0;
      out_row   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            klen_q  <= k_len;
            cnt     <= '0;
            fcnt    <= '0;
            out_row <= '0;
            busy    <= 1'b1;
            if (k_len == '0) begin
              state <= S_FLUSH;
            end else begin
              state    <= S_FEED;
              in_ready <= 1'b1;
            end
          end
        end
        S_FEED: begin
          if (fire) begin
            cnt <= cnt + 1'b1;
            if (cnt + 1'b1 == klen_q) begin
              state    <= S_FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        S_FLUSH: begin
          fcnt <= fcnt + 1'b1;
          if (fcnt == FLUSH_LAST) begin
            state     <= S_DRAIN;
            out_valid <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            if (out_row == ROW_LAST) begin
              state     <= S_IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              out_row   <= '0;
            end else begin
              out_row <= out_row + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Row r / column c skewed by r / c cycles so PE(r,c) sees aligned beats.
  for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
    assign a_inj[r] = fire ? ifmap_in[DW*r +: DW] : '0;
    if (r == 0) begin : g_direct
      assign a_bus[r][0] = a_inj[r];
    end else begin : g_delay
      logic signed [DW-1:0] sr [r];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
        end else begin
          sr[0] <= a_inj[r];
          for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
        end
      end
      assign a_bus[r][0] = sr[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col_skew
    assign b_inj[c] = fire ? weight_in[DW*c +: DW] : '0;
    if (c == 0) begin : g_direct
      assign b_bus[0][c] = b_inj[c];
    end else begin : g_delay
      logic signed [DW-1:0] sr [c];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < c; i++) sr[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < c; i++) sr[i] <= '0;
        end else begin
          sr[0] <= b_inj[c];
          for (int i = 1; i < c; i++) sr[i] <= sr[i-1];
        end
      end
      assign b_bus[0][c] = sr[c-1];
    end
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_r
    for (genvar c = 0; c < COLS; c++) begin : g_c
      systolic_os_pe #(
        .DW   (DW),
        .ACCW (ACCW)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (en),
        .a_in  (a_bus[r][c]),
        .b_in  (b_bus[r][c]),
        .a_out (a_bus[r][c+1]),
        .b_out (b_bus[r+1][c]),
        .acc   (acc_arr[r][c])
      );
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    logic signed [ACCW-1:0] sel;
    logic        [DW-1:0]   lane;
    assign sel = acc_arr[out_row][c];
`ifdef SYSTOLIC_OUT_SAT_EN
    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(2**(DW-1) - 1);
    localparam logic signed [ACCW-1:0] SAT_MIN = -SAT_MAX - 1;
    assign lane = (sel > SAT_MAX) ? {1'b0, {(DW-1){1'b1}}} :
                  (sel < SAT_MIN) ? {1'b1, {(DW-1){1'b0}}} :
                  sel[DW-1:0];
`else
    logic unused_hi;
    assign unused_hi = ^sel[ACCW-1:DW];
    assign lane = sel[DW-1:0];
`endif
    assign out_data[DW*c +: DW] = out_valid ? lane : '0;
  end

endmodule

// File: tb/tb_systolic_os_array.sv
// Directed self-checking bench for systolic_os_array (4x4, DW=8).
module tb_systolic_os_array;

  localparam int DW   = 8;
  localparam int R    = 4;
  localparam int C    = 4;
  localparam int KMAX = 256;
  localparam int KW   = $clog2(KMAX + 1);

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [KW-1:0]   k_len = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [R*DW-1:0] ifmap_in = '0;
  logic [C*DW-1:0] weight_in = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [1:0]      out_row;
  logic [C*DW-1:0] out_data;
  logic            busy;
  logic            done;

  int total = 0;
  int bad = 0;
  int ifm [8][R];
  int wgt [8][C];
  int expm [R][C];

  systolic_os_array #(
    .DW   (DW),
    .ROWS (R),
    .COLS (C),
    .KMAX (KMAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_len     (k_len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ifmap_in  (ifmap_in),
    .weight_in (weight_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_row   (out_row),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, int got, int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int lane(int c);
    logic [DW-1:0] v;
    v = out_data[c*DW +: DW];
    return int'($signed(v));
  endfunction

  task automatic begin_tile(int k);
    @(negedge clk);
    start = 1'b1;
    k_len = KW'(k);
    @(negedge clk);
    start = 1'b0;
    chk("busy_start", int'(busy), 1);
  endtask

  task automatic feed(int k, bit toggle);
    int i;
    int cyc;
    bit v;
    i = 0;
    cyc = 0;
    while (i < k && cyc < 200) begin
      v = !(toggle && (cyc % 2 == 1));
      in_valid = v;
      for (int r = 0; r < R; r++) begin
        logic [31:0] t;
        t = v ? ifm[i][r] : 32'h55;
        ifmap_in[r*DW +: DW] = t[DW-1:0];
      end
      for (int c = 0; c < C; c++) begin
        logic [31:0] t;
        t = v ? wgt[i][c] : 32'h55;
        weight_in[c*DW +: DW] = t[DW-1:0];
      end
      if (v && in_ready) i++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    if (i < k) chk("feed_timeout", i, k);
  endtask

  task automatic drain(int stall_row);
    int w;
    w = 0;
    while (!out_valid && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!out_valid) begin
      chk("drain_wait", 0, 1);
      return;
    end
    for (int r = 0; r < R; r++) begin
      if (r == stall_row) begin
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          chk($sformatf("stall%0d_row", s), int'(out_row), r);
          for (int c = 0; c < C; c++)
            chk($sformatf("stall%0d_c%0d", s, c), lane(c), expm[r][c]);
          @(negedge clk);
        end
      end
      out_ready = 1'b1;
      chk($sformatf("row%0d_idx", r), int'(out_row), r);
      chk($sformatf("row%0d_vld", r), int'(out_valid), 1);
      chk($sformatf("row%0d_nodone", r), int'(done), 0);
      for (int c = 0; c < C; c++)
        chk($sformatf("r%0d_c%0d", r, c), lane(c), expm[r][c]);
      @(negedge clk);
    end
    out_ready = 1'b0;
    chk("done_pulse", int'(done), 1);
    chk("busy_end", int'(busy), 0);
    chk("vld_end", int'(out_valid), 0);
    @(negedge clk);
    chk("done_once", int'(done), 0);
  endtask

  task automatic set_const(int a, int b, int e);
    for (int k = 0; k < 8; k++) begin
      for (int r = 0; r < R; r++) ifm[k][r] = a;
      for (int c = 0; c < C; c++) wgt[k][c] = b;
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) expm[r][c] = e;
  endtask

  initial begin
    int seen;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_out_row", int'(out_row), 0);
    chk("rst_out_data", int'(out_data != '0), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_in_ready", int'(in_ready), 0);

    // 3 * 2, one beat
    set_const(3, 2, 6);
    begin_tile(1);
    feed(1, 1'b0);
    drain(-1);

    // identity weights: result equals ifmap matrix
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < R; r++) ifm[k][r] = 10 * r + k + 1;
      for (int c = 0; c < C; c++) wgt[k][c] = (k == c) ? 1 : 0;
    end
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++) expm[r][c] = 10 * r + c + 1;
    begin_tile(4);
    feed(4, 1'b0);
    drain(-1);
    begin_tile(4);
    feed(4, 1'b1);
    drain(2);

    // 4 * 127 * 127 = 64516
`ifdef SYSTOLIC_OUT_SAT_EN
    set_const(127, 127, 127);
`else
    set_const(127, 127, 4);
`endif
    begin_tile(4);
    feed(4, 1'b0);
    drain(-1);

    // empty tile
    set_const(0, 0, 0);
    begin_tile(0);
    chk("k0_in_ready", int'(in_ready), 0);
    drain(-1);

    // start during FEED must not relatch k_len
    set_const(1, 1, 2);
    begin_tile(2);
    start = 1'b1;
    k_len = KW'(1);
    @(negedge clk);
    start = 1'b0;
    feed(2, 1'b0);
    drain(-1);

    // reset in the middle of FLUSH
    set_const(3, 2, 6);
    begin_tile(1);
    feed(1, 1'b0);
    repeat (2) @(negedge clk);
    chk("flush_busy", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_in_ready", int'(in_ready), 0);
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_out_row", int'(out_row), 0);
    chk("mid_rst_out_data", int'(out_data != '0), 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (done || out_valid || busy) seen++;
    end
    chk("no_done_after_rst", seen, 0);

    set_const(5, -1, -5);
    begin_tile(1);
    feed(1, 1'b0);
    drain(-1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=1 exp=0");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/systolic_os_array.md
SYSTOLIC_OS_ARRAY -- requirements
Module: systolic_os_array

Interface
REQ-001 SHALL have parameters DW=16 (signed operand width), ROWS=16 (PE rows), COLS=16 (PE columns), KMAX=256 (max reduction length), ACCW=2*DW+$clog2(KMAX) (accumulator width).
REQ-002 SHALL have ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  begin one tile.
- k_len  in  $clog2(KMAX+1)  beats per tile, sampled on accepted start.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  operand beat accepted.
- ifmap_in  in  ROWS*DW  signed; row r in slice [DW*(r+1)-1:DW*r].
- weight_in  in  COLS*DW  signed; column c in slice [DW*(c+1)-1:DW*c].
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts row.
- out_row  out  $clog2(ROWS)  row index of out_data.
- out_data  out  COLS*DW  signed results of one row.
- busy  out  1  tile in progress.
- done  out  1  one-cycle pulse after the last row is accepted.

Function
REQ-003 SHALL be an output-stationary ROWS x COLS array; ifmap moves west->east one PE per cycle, weight moves north->south one PE per cycle.
REQ-004 SHALL skew inputs internally: ifmap row r delayed r cycles, weight column c delayed c cycles, so PE(r,c) multiplies the same beat index.
REQ-005 SHALL compute per PE acc += ifmap*weight, full 2*DW-bit signed product, ACCW-bit accumulator, two's-complement wrap on overflow.
REQ-006 SHALL implement FSM IDLE, FEED, FLUSH, DRAIN; reset state IDLE.
REQ-007 IDLE: busy=0, in_ready=0; start=1 latches k_len, clears all accumulators and skew registers, -> FEED (or FLUSH if k_len=0).
REQ-008 FEED: in_ready=1; a beat transfers when in_valid&in_ready; after beat k_len -> FLUSH; cycles without in_valid inject zero operands (bubbles add zero).
REQ-009 FLUSH: in_ready=0, zero operands injected for exactly ROWS+COLS-1 cycles, then -> DRAIN.
REQ-010 DRAIN: out_valid=1, out_row counts 0..ROWS-1, advancing only when out_valid&out_ready; out_data held stable while stalled.
REQ-011 After row ROWS-1 accepted: done=1 for one cycle, -> IDLE.
REQ-012 start SHALL be ignored while busy=1; busy=1 in FEED, FLUSH, DRAIN.
REQ-013 Accumulators SHALL NOT change in DRAIN.
REQ-014 k_len=0 SHALL yield all-zero rows.

Reset
REQ-015 rst low SHALL asynchronously clear FSM to IDLE, all accumulators, skew and pipeline registers, counters; in_ready, out_valid, busy, done, out_row, out_data = 0.
REQ-016 Reset mid-tile SHALL abandon the tile; no done pulse; next start begins cleanly.

Configuration
REQ-017 Macro SYSTOLIC_OUT_SAT_EN defined: each out_data lane = accumulator saturated to signed DW range [-2^(DW-1), 2^(DW-1)-1].
REQ-018 Macro undefined: each out_data lane = accumulator bits [DW-1:0] (wrap).

Structure
REQ-019 Shared package SHALL hold FSM state encoding and the ACCW derivation function; no other constants.
REQ-020 One sub-module, systolic_os_pe (MAC, operand forwarding registers, synchronous clear), SHALL be instantiated ROWS*COLS times.

Verification
REQ-021 ROWS=COLS=4, DW=8, k_len=1, ifmap all 3, weight all 2, continuous valid -> 4 rows, every lane 6, done once.
REQ-022 k_len=4, identity-pattern weights, ifmap rows 1..4 -> out_data matches golden matrix product; in_valid toggled every other cycle gives identical result.
REQ-023 out_ready held low 5 cycles in DRAIN row 2 -> out_row=2 and out_data stable for all 5 cycles, no row skipped.
REQ-024 DW=8, k_len=4, ifmap=127, weight=127 (acc 64516) -> with SYSTOLIC_OUT_SAT_EN lanes = 127; without, lanes = 64516 mod 256 as signed (4).
REQ-025 k_len=0 -> 4 zero rows then done; start pulse during FEED ignored (k_len unchanged).
REQ-026 rst asserted mid-FLUSH -> all outputs 0 next edge, busy=0, no done; new start with k_len=1 gives correct result.
